edge_period_meter: RTL and testbench
====================================

# edge_period_meter

Receive-side companion to the clock divider: takes a slow, asynchronous square wave (a divided clock or any external toggling signal), synchronizes it into the system clock domain, emits single-cycle rising/falling edge ticks, and measures its period and high time in system-clock cycles. Game logic uses the ticks as clock enables in place of the divided clock. The measurements support self-check and debug display. A timeout flags a stalled input.

## Interface
- MAX_PERIOD, 67108863: longest accepted period in clk cycles; longer gaps time out.
- COUNT_W, $clog2(MAX_PERIOD+1): width of the measurement outputs and internal counters.

- clk  input  1  system clock (25 MHz).
- reset  input  1  asynchronous, active-high reset.
- sig_in  input  1  asynchronous slow square wave.
- clear  input  1  synchronous restart of measurement, one cycle.
- rise_tick  output  1  one-cycle pulse per synchronized rising edge.
- fall_tick  output  1  one-cycle pulse per synchronized falling edge.
- period  output  COUNT_W  cycles between the last two rise_ticks.
- high_time  output  COUNT_W  cycles from rise_tick to fall_tick within that period.
- period_valid  output  1  level; period/high_time hold a complete measurement.
- period_strobe  output  1  one-cycle pulse when period/high_time update.
- timeout  output  1  level; no rising edge within MAX_PERIOD cycles.

## Operation
- Synchronizer: s1 and s2 form a two-flop chain, and s3 is the previous s2. All reset to 0. clear does not affect them.
- rise_tick is the registered value of s2 & ~s3. fall_tick is the registered value of ~s2 & s3. Ticks never depend on state or on clear.
- Elapsed counter `el` resets to 1 in the cycle after a rise event. Otherwise it increments, saturating at MAX_PERIOD+1.
- The high counter counts cycles from the rise event up to the fall event.
- States:
  - WAIT_FIRST: the reset and clear state. There is no reference edge yet. On a rise event, go to MEASURING. Outputs are unchanged.
  - MEASURING: on a rise event, load period with `el` and load high_time with the high count. Pulse period_strobe, set period_valid, and stay in MEASURING. If `el` reaches MAX_PERIOD+1 with no rise, go to TIMEOUT.
  - TIMEOUT: timeout=1 and period_valid=0. period/high_time keep their last values. On a rise event, go to MEASURING with this edge as the new reference. There is no update on that edge, and timeout clears.
  - WAIT_FIRST also times out: `el` counts from reset or clear. If MAX_PERIOD+1 cycles pass with no rise, go to TIMEOUT.
- A period of exactly MAX_PERIOD is accepted. MAX_PERIOD+1 times out.
- If no fall occurs between rises, high_time equals period, saturating at MAX_PERIOD. A signal stuck high eventually times out.
- clear, in any state:
  - Next state is WAIT_FIRST.
  - period and high_time go to 0. period_valid, period_strobe and timeout go to 0.
  - Counters restart.
- clear takes priority over a simultaneous rise event. That rise is not used as a reference, though rise_tick still pulses.

## Timing
- Reset values: every output is 0, state is WAIT_FIRST, and all flops are 0.
- If sig_in is high when reset releases, one rise_tick occurs and is taken as the first reference.
- rise_tick/fall_tick: high for exactly one cycle, starting after the 3rd rising clk edge following a sig_in transition (sig_in stable for setup before edge 1).
- period, high_time, period_strobe and period_valid all update on the same clk edge as the corresponding rise_tick assertion. They are registered, with no combinational path from sig_in.
- Minimum resolvable input: 2 cycles high and 2 cycles low. Narrower pulses may be missed, and a missed pulse must not corrupt state.
- A divider with terminal count T yields period = 2(T+1) and high_time = T+1.

## Test plan
- Reset, then sig_in low for 100 cycles -> all outputs 0; no ticks; state WAIT_FIRST.
- sig_in toggles every 10 cycles (MAX_PERIOD=64) -> rise_tick every 20 cycles, 3 cycles after each sig_in rise. fall_tick midway. First strobe at the 2nd rise_tick with period=20, high_time=10, period_valid=1. A strobe follows every 20 cycles.
- Same wave with a duty change to 5 high/15 low -> at the next strobe, period=20, high_time=5.
- MAX_PERIOD=64, then sig_in held low after a valid measurement -> timeout=1 and period_valid=0 exactly 65 cycles after the last rise_tick; period stays 20. Toggling resumes -> first rise clears timeout with no strobe; the second rise strobes the new period.
- Period exactly 64 -> accepted with period=64. Period 65 -> timeout.
- clear asserted in the same cycle as a rise_tick mid-stream -> rise_tick still pulses. Outputs go to 0 and state goes to WAIT_FIRST. The next rise is the reference, and the one after it produces the first strobe.
- reset asserted mid-measurement -> all outputs 0 immediately (asynchronously), and measurement restarts cleanly after release.

Source files
------------

// File: rtl/edge_period_meter_if.sv
// Signal-side bundle for edge_period_meter: the slow input, the clear request,
// the edge ticks and the period/high-time measurement results.
interface edge_period_meter_if #(
  parameter int COUNT_W = 26
);
  logic               sig_in;
  logic               clear;
  logic               rise_tick;
  logic               fall_tick;
  logic [COUNT_W-1:0] period;
  logic [COUNT_W-1:0] high_time;
  logic               period_valid;
  logic               period_strobe;
  logic               timeout;

  modport slave (
    input  sig_in, clear,
    output rise_tick, fall_tick, period, high_time,
           period_valid, period_strobe, timeout
  );

  modport master (
    output sig_in, clear,
    input  rise_tick, fall_tick, period, high_time,
           period_valid, period_strobe, timeout
  );
endinterface

// File: rtl/edge_period_meter.sv
// Synchronizes a slow asynchronous square wave, emits one-cycle edge ticks and
// measures its period and high time in clk cycles, flagging a stalled input.
module edge_period_meter #(
  parameter int MAX_PERIOD = 67108863,
  parameter int COUNT_W    = $clog2(MAX_PERIOD + 1)
) (
  input  logic              clk,
  input  logic              reset,
  edge_period_meter_if.slave bus
);

  // el must also hold the saturation value MAX_PERIOD+1, which can need one
  // more bit than the measurement outputs.
  localparam int EL_W = $clog2(MAX_PERIOD + 2);
  localparam logic [EL_W-1:0]    EL_SAT = EL_W'(MAX_PERIOD + 1);
  localparam logic [COUNT_W-1:0] HC_MAX = COUNT_W'(MAX_PERIOD);

  localparam logic [1:0] WAIT_FIRST = 2'd0;
  localparam logic [1:0] MEASURING  = 2'd1;
  localparam logic [1:0] TIMEOUT    = 2'd2;

  logic               s1, s2, s3;
  logic               rise_ev, fall_ev;
  logic               rise_q, fall_q;
  logic [EL_W-1:0]    el;
  logic [COUNT_W-1:0] hc;
  logic               el_sat;
  logic [1:0]         state;
  logic [COUNT_W-1:0] period_q, high_q;
  logic               valid_q, strobe_q, timeout_q;

  assign rise_ev = s2 & ~s3;
  assign fall_ev = ~s2 & s3;
  assign el_sat  = (el == EL_SAT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      s3     <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      s1     <= bus.sig_in;
      s2     <= s1;
      s3     <= s2;
      rise_q <= rise_ev;
      fall_q <= fall_ev;
    end
  end

  // hc only advances while the synchronized input is high, so at the next
  // rise it holds the cycles from the previous rise to the intervening fall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      el <= '0;
      hc <= '0;
    end else if (bus.clear) begin
      el <= '0;
      hc <= '0;
    end else begin
      if (rise_ev)
        el <= EL_W'(1);
      else if (!el_sat)
        el <= el + EL_W'(1);

      if (rise_ev)
        hc <= COUNT_W'(1);
      else if (s2 && (hc != HC_MAX))
        hc <= hc + COUNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= WAIT_FIRST;
      period_q  <= '0;
      high_q    <= '0;
      valid_q   <= 1'b0;
      strobe_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      strobe_q <= 1'b0;
      if (bus.clear) begin
        state     <= WAIT_FIRST;
        period_q  <= '0;
        high_q    <= '0;
        valid_q   <= 1'b0;
        timeout_q <= 1'b0;
      end else begin
        case (state)
          WAIT_FIRST: begin
            if (rise_ev) begin
              state <= MEASURING;
            end else if (el_sat) begin
              state     <= TIMEOUT;
              timeout_q <= 1'b1;
              valid_q   <= 1'b0;
            end
          end
          MEASURING: begin
            // A rise arriving only once el has saturated is already too late.
            if (el_sat) begin
              state     <= TIMEOUT;
              timeout_q <= 1'b1;
              valid_q   <= 1'b0;
            end else if (rise_ev) begin
              period_q <= COUNT_W'(el);
              high_q   <= hc;
              strobe_q <= 1'b1;
              valid_q  <= 1'b1;
            end
          end
          TIMEOUT: begin
            if (rise_ev) begin
              state     <= MEASURING;
              timeout_q <= 1'b0;
            end
          end
          default: state <= WAIT_FIRST;
        endcase
      end
    end
  end

  assign bus.rise_tick     = rise_q;
  assign bus.fall_tick     = fall_q;
  assign bus.period        = period_q;
  assign bus.high_time     = high_q;
  assign bus.period_valid  = valid_q;
  assign bus.period_strobe = strobe_q;
  assign bus.timeout       = timeout_q;

endmodule

// File: tb/tb_edge_period_meter.sv
// Self-checking bench for edge_period_meter: directed waveforms plus random
// pulse trains, compared every cycle against an event-level reference model.
module tb_edge_period_meter;

  localparam int MAXP = 64;
  localparam int CW   = $clog2(MAXP + 1);

  logic clk = 1'b0;
  logic reset;

  edge_period_meter_if #(.COUNT_W(CW)) bus ();

  edge_period_meter #(
    .MAX_PERIOD(MAXP),
    .COUNT_W(CW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #20 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, got, exp);
    end
  endtask

  // Reference model: tracks edge indices of rise/fall events and derives the
  // measurements as differences between them.
  localparam int M_WAIT = 0, M_MEAS = 1, M_TO = 2;
  int m = 0, vref = 1, ref_e = 0, fall_m = -1, mode = M_WAIT;
  int e_period = 0, e_ht = 0;
  bit e_rise = 0, e_fall = 0, e_valid = 0, e_strobe = 0, e_to = 0;
  bit x1 = 0, x2 = 0, x3 = 0;   // sig_in as sampled 1, 2 and 3 edges ago
  bit rise_e, fall_e;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m = 0; vref = 1; ref_e = 0; fall_m = -1; mode = M_WAIT;
      e_period = 0; e_ht = 0;
      e_rise = 0; e_fall = 0; e_valid = 0; e_strobe = 0; e_to = 0;
      x1 = 0; x2 = 0; x3 = 0;
    end else begin
      m = m + 1;
      rise_e = x2 && !x3;
      fall_e = !x2 && x3;
      e_rise = rise_e;
      e_fall = fall_e;
      e_strobe = 0;
      if (bus.clear) begin
        mode = M_WAIT; vref = m + 1;
        e_period = 0; e_ht = 0; e_valid = 0; e_to = 0;
      end else if (mode == M_WAIT) begin
        if (rise_e) begin
          mode = M_MEAS; ref_e = m;
        end else if (m - vref > MAXP) begin
          mode = M_TO; e_to = 1; e_valid = 0;
        end
      end else if (mode == M_MEAS) begin
        if (m - ref_e > MAXP) begin
          mode = M_TO; e_to = 1; e_valid = 0;
        end else if (rise_e) begin
          e_period = m - ref_e;
          e_ht     = (fall_m > ref_e) ? fall_m - ref_e : m - ref_e;
          if (e_ht > MAXP) e_ht = MAXP;
          e_strobe = 1; e_valid = 1; ref_e = m;
        end
      end else if (rise_e) begin
        mode = M_MEAS; ref_e = m; e_to = 0;
      end
      if (fall_e) fall_m = m;
      x3 = x2; x2 = x1; x1 = bus.sig_in;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check_val("rise_tick",     bus.rise_tick,     e_rise);
      check_val("fall_tick",     bus.fall_tick,     e_fall);
      check_val("period",        bus.period,        e_period);
      check_val("high_time",     bus.high_time,     e_ht);
      check_val("period_valid",  bus.period_valid,  e_valid);
      check_val("period_strobe", bus.period_strobe, e_strobe);
      check_val("timeout",       bus.timeout,       e_to);
    end
  end

  // Called at a negedge; holds sig_in at lvl for len cycles, pulsing clear
  // during cycle clr_at (negative means no clear).
  task automatic drive(input logic lvl, input int len, input int clr_at);
    for (int i = 0; i < len; i++) begin
      bus.sig_in = lvl;
      bus.clear  = (i == clr_at);
      @(negedge clk);
    end
    bus.clear = 1'b0;
  endtask

  task automatic wave(input int hi, input int lo, input int n);
    for (int k = 0; k < n; k++) begin
      drive(1'b1, hi, -1);
      drive(1'b0, lo, -1);
    end
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset      = 1'b1;
    bus.sig_in = 1'b0;
    bus.clear  = 1'b0;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    reset  = 1'b0;

    // Idle low: no ticks, and the wait for a first edge eventually times out.
    drive(1'b0, 100, -1);
    check_val("idle_timeout", bus.timeout, 1);

    wave(10, 10, 6);
    check_val("sq_period", bus.period, 20);
    check_val("sq_high",   bus.high_time, 10);
    check_val("sq_valid",  bus.period_valid, 1);

    wave(5, 15, 3);
    check_val("duty_high", bus.high_time, 5);

    drive(1'b0, 100, -1);
    check_val("stall_timeout", bus.timeout, 1);
    check_val("stall_valid",   bus.period_valid, 0);
    check_val("stall_period",  bus.period, 20);
    wave(10, 10, 4);
    check_val("resume_timeout", bus.timeout, 0);

    wave(32, 32, 3);
    check_val("max_period", bus.period, 64);
    check_val("max_valid",  bus.period_valid, 1);
    wave(33, 32, 2);
    check_val("over_timeout", bus.timeout, 1);

    // clear sampled on the same edge as a rise event, then on a tick cycle.
    wave(10, 10, 3);
    drive(1'b1, 10, 2);
    check_val("clr_valid",  bus.period_valid, 0);
    check_val("clr_period", bus.period, 0);
    drive(1'b0, 10, -1);
    wave(10, 10, 3);
    drive(1'b1, 10, 3);
    drive(1'b0, 10, -1);
    wave(10, 10, 3);

    // Asynchronous reset mid-measurement.
    wave(12, 8, 3);
    drive(1'b1, 6, -1);
    #3 reset = 1'b1;
    #1;
    check_val("arst_period", bus.period, 0);
    check_val("arst_high",   bus.high_time, 0);
    check_val("arst_valid",  bus.period_valid, 0);
    check_val("arst_rise",   bus.rise_tick, 0);
    @(negedge clk);
    drive(1'b1, 2, -1);
    reset = 1'b0;   // sig_in high at release: first rise_tick is the reference
    drive(1'b1, 6, -1);
    drive(1'b0, 10, -1);
    wave(10, 10, 3);
    check_val("post_rst_period", bus.period, 20);

    // Random pulse trains including narrow pulses, stalls and clears.
    for (int k = 0; k < 70; k++) begin
      int hi, lo, ca;
      hi = $urandom_range(1, 30);
      lo = ($urandom_range(0, 11) == 0) ? $urandom_range(55, 75) : $urandom_range(1, 30);
      ca = ($urandom_range(0, 9) == 0) ? $urandom_range(0, hi - 1) : -1;
      drive(1'b1, hi, ca);
      drive(1'b0, lo, -1);
    end

    drive(1'b0, 5, -1);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
